// File: rtl/uart_defs.sv
// Shared UART types: frame configuration, TX status word and TX state encoding,
// plus helpers that decode the configured data length.
package uart_defs;

    localparam int DATA_MAX = 9;

    typedef struct packed {
        logic [3:0] frame_len;
        logic       parity;
        logic       dstop;
        logic       flow_control;
        logic       flush_tx;
    } Config_t;

    typedef struct packed {
        logic busy;
        logic fifo_full;
        logic fifo_empty;
    } TXStatus_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DSTOP
    } TXState_t;

    // Lowest set bit of frame_len selects 5..8 data bits; none set means 9.
    function automatic logic [3:0] data_len(input logic [3:0] frame_len);
        logic [3:0] n;
        if (frame_len[0])      n = 4'd5;
        else if (frame_len[1]) n = 4'd6;
        else if (frame_len[2]) n = 4'd7;
        else if (frame_len[3]) n = 4'd8;
        else                   n = 4'd9;
        return n;
    endfunction

    function automatic logic [DATA_MAX-1:0] len_mask(input logic [3:0] n);
        logic [DATA_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (i < int'(n)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered full/empty flags and a same-cycle flush.
// buffer_size must be a power of two so the pointers wrap naturally.
module fifo_sync #(
    parameter int data_size   = 9,
    parameter int buffer_size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [data_size-1:0] enq_data,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [data_size-1:0] deq_data,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(buffer_size);

    logic [data_size-1:0] mem [buffer_size];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [AW:0]          count_next;
    logic                 do_enq;
    logic                 do_deq;

    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign deq_data  = mem[rd_ptr];

    // A flush wins over any enqueue or dequeue in the same cycle.
    assign do_enq = enq_valid & ~full & ~flush;
    assign do_deq = deq_ready & ~empty & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + (AW+1)'(do_enq) - (AW+1)'(do_deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_enq) wr_ptr <= wr_ptr + 1'b1;
                if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(buffer_size));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered words serialized as start, 5-9 data bits
// (LSB first), optional odd parity and one or two stop bits, paced by baud_tick_i.
module uart_tx
    import uart_defs::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      baud_tick_i,
    input  logic      tx_enable_i,
    input  logic [8:0] tx_d_i,
    input  logic      tx_d_valid_i,
    output logic      tx_d_ready_o,
    output logic      tx_o,
    input  logic      cts_n_i,
    output logic      tx_done_o,
    output TXStatus_t tx_status_o,
    input  Config_t   uart_config_i
);

    TXState_t   state;
    TXState_t   state_next;
    logic [8:0] shift;
    logic [8:0] shift_next;
    logic [8:0] head;
    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_next;
    logic [3:0] last_bit;
    logic [3:0] last_bit_next;
    logic [3:0] cfg_len;
    logic       par_en;
    logic       par_en_next;
    logic       dstop_en;
    logic       dstop_en_next;
    logic       par_bit;
    logic       par_bit_next;
    logic       tx_next;
    logic       done_next;
    logic       pop;
    logic       load;
    logic       launch;
    logic       head_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       cts_meta;
    logic       cts_sync;
    logic       cts_ok;

    fifo_sync #(
        .data_size  (9),
        .buffer_size(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (uart_config_i.flush_tx),
        .enq_valid(tx_d_valid_i),
        .enq_ready(tx_d_ready_o),
        .enq_data (tx_d_i),
        .deq_valid(head_valid),
        .deq_ready(pop),
        .deq_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // cts_n_i is asynchronous; reset to "not clear" so nothing launches early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts_n_i;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok  = ~uart_config_i.flow_control | ~cts_sync;
    assign launch  = baud_tick_i & tx_enable_i & head_valid & cts_ok;
    assign cfg_len = data_len(uart_config_i.frame_len);

    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_cnt_next  = bit_cnt;
        last_bit_next = last_bit;
        par_en_next   = par_en;
        dstop_en_next = dstop_en;
        par_bit_next  = par_bit;
        done_next     = 1'b0;
        load          = 1'b0;
        tx_next       = 1'b1;

        if (baud_tick_i) begin
            case (state)
                IDLE: begin
                    load = launch;
                end
                START: begin
                    state_next   = DATA;
                    bit_cnt_next = last_bit;
                end
                DATA: begin
                    if (bit_cnt == 4'd0) begin
                        state_next = par_en ? PARITY : STOP;
                    end else begin
                        shift_next   = {1'b0, shift[8:1]};
                        bit_cnt_next = bit_cnt - 4'd1;
                    end
                end
                PARITY: begin
                    state_next = STOP;
                end
                STOP: begin
                    if (dstop_en) begin
                        state_next = DSTOP;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                        load       = launch;
                    end
                end
                DSTOP: begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                    load       = launch;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Frame format is captured here so later config changes cannot disturb it.
        if (load) begin
            state_next    = START;
            shift_next    = head;
            last_bit_next = cfg_len - 4'd1;
            par_en_next   = uart_config_i.parity;
            dstop_en_next = uart_config_i.dstop;
            par_bit_next  = ~^(head & len_mask(cfg_len));
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit_next;
            default: tx_next = 1'b1;
        endcase
    end

    assign pop = load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            last_bit  <= '0;
            par_en    <= 1'b0;
            dstop_en  <= 1'b0;
            par_bit   <= 1'b0;
            tx_o      <= 1'b1;
            tx_done_o <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            bit_cnt   <= bit_cnt_next;
            last_bit  <= last_bit_next;
            par_en    <= par_en_next;
            dstop_en  <= dstop_en_next;
            par_bit   <= par_bit_next;
            tx_o      <= tx_next;
            tx_done_o <= done_next;
        end
    end

    assign tx_status_o = {(state != IDLE), fifo_full, fifo_empty};

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fixed frame vectors, randomized batches
// against a frame-level model, and hand sequences for FIFO fill, CTS and reset.
module tb_uart_tx;
    import uart_defs::*;

    localparam int DEPTH = 8;
    localparam int BAUD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick_i = 1'b0;
    logic       tx_enable_i = 1'b0;
    logic [8:0] tx_d_i = '0;
    logic       tx_d_valid_i = 1'b0;
    logic       tx_d_ready_o;
    logic       tx_o;
    logic       cts_n_i = 1'b1;
    logic       tx_done_o;
    TXStatus_t  tx_status_o;
    Config_t    cfg = '0;

    int    vectors_applied = 0;
    int    miscompares = 0;
    logic  tick_en = 1'b0;
    int    div = 0;
    logic  line_q[$];
    int    done_total = 0;
    string exp_q[$];

    typedef struct {
        logic [8:0] data;
        logic [3:0] frame_len;
        logic       parity;
        logic       dstop;
        string      bits;
    } vec_t;

    vec_t vecs[6];

    uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick_i  (baud_tick_i),
        .tx_enable_i  (tx_enable_i),
        .tx_d_i       (tx_d_i),
        .tx_d_valid_i (tx_d_valid_i),
        .tx_d_ready_o (tx_d_ready_o),
        .tx_o         (tx_o),
        .cts_n_i      (cts_n_i),
        .tx_done_o    (tx_done_o),
        .tx_status_o  (tx_status_o),
        .uart_config_i(cfg)
    );

    always #5 clk = ~clk;

    // Tick generator and line monitor share one process so the sample of tx_o
    // always belongs to the bit period that the coming tick edge ends.
    always @(negedge clk) begin
        if (tx_done_o) done_total++;
        if (!tick_en) begin
            div = 0;
            baud_tick_i = 1'b0;
        end else begin
            baud_tick_i = (div == BAUD - 1);
            div = (div + 1) % BAUD;
            if (baud_tick_i) line_q.push_back(tx_o);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic string bit_char(input logic b);
        if (b === 1'b1) return "1";
        if (b === 1'b0) return "0";
        return "x";
    endfunction

    // Frame model: line level for each bit period, in time order.
    function automatic string model_frame(input logic [8:0] data, input Config_t c);
        int    n;
        int    ones;
        string s;
        n = 9;
        for (int b = 3; b >= 0; b--) begin
            if (c.frame_len[b]) n = 5 + b;
        end
        s = "0";
        ones = 0;
        for (int i = 0; i < n; i++) begin
            s = {s, bit_char(data[i])};
            if (data[i]) ones++;
        end
        if (c.parity) begin
            if (ones % 2 == 0) s = {s, "1"};
            else               s = {s, "0"};
        end
        s = {s, "1"};
        if (c.dstop) s = {s, "1"};
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_frame(input string name, input string act, input string exp);
        vectors_applied++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: line %s, expected %s", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [8:0] d);
        tx_d_valid_i = 1'b1;
        tx_d_i = d;
        @(negedge clk);
        tx_d_valid_i = 1'b0;
    endtask

    // Compares the monitored line from index mark against exp_q, frames
    // back to back after any idle ones, and requires idle afterwards.
    task automatic check_stream(input string name, input int mark);
        int    pos;
        int    zeros;
        string act;
        pos = mark;
        while (pos < line_q.size() && line_q[pos] === 1'b1) pos++;
        foreach (exp_q[f]) begin
            act = "";
            for (int i = 0; i < exp_q[f].len(); i++) begin
                if (pos < line_q.size()) act = {act, bit_char(line_q[pos])};
                else                     act = {act, "-"};
                pos++;
            end
            check_frame($sformatf("%s frame%0d", name, f), act, exp_q[f]);
        end
        zeros = 0;
        while (pos < line_q.size()) begin
            if (line_q[pos] !== 1'b1) zeros++;
            pos++;
        end
        check_output({name, " idle"}, zeros, 0);
    endtask

    task automatic apply_stimulus(input string name, input int n_frames);
        int mark;
        int d0;
        int c;
        mark = line_q.size();
        d0 = done_total;
        tick_en = 1'b1;
        c = 0;
        while (done_total - d0 < n_frames && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (3 * BAUD) @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        check_output({name, " done count"}, done_total - d0, n_frames);
        check_stream(name, mark);
        check_output({name, " busy after"}, tx_status_o.busy, 0);
    endtask

    initial begin
        int         c;
        int         n;
        int         mark;
        int         d0;
        logic [8:0] w;

        vecs[0] = '{9'h0A5, 4'b1000, 1'b0, 1'b0, "0101001011"};
        vecs[1] = '{9'h0A5, 4'b1000, 1'b1, 1'b1, "010100101111"};
        vecs[2] = '{9'h1FF, 4'b0001, 1'b1, 1'b0, "01111101"};
        vecs[3] = '{9'h100, 4'b0000, 1'b0, 1'b0, "00000000011"};
        vecs[4] = '{9'h055, 4'b1100, 1'b1, 1'b0, "0101010111"};
        vecs[5] = '{9'h02A, 4'b0110, 1'b1, 1'b1, "0010101011"};

        repeat (3) @(negedge clk);
        check_output("reset tx_o", tx_o, 1);
        check_output("reset ready", tx_d_ready_o, 1);
        check_output("reset done", tx_done_o, 0);
        check_output("reset status", tx_status_o, 3'b001);
        rst_n = 1'b1;
        tx_enable_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cfg = '0;
            cfg.frame_len = vecs[i].frame_len;
            cfg.parity = vecs[i].parity;
            cfg.dstop = vecs[i].dstop;
            write_word(vecs[i].data);
            exp_q.delete();
            exp_q.push_back(vecs[i].bits);
            apply_stimulus($sformatf("vec%0d", i), 1);
        end

        for (int it = 0; it < 8; it++) begin
            cfg = '0;
            cfg.frame_len = 4'($urandom_range(0, 15));
            cfg.parity = 1'($urandom_range(0, 1));
            cfg.dstop = 1'($urandom_range(0, 1));
            n = $urandom_range(1, DEPTH);
            exp_q.delete();
            for (int k = 0; k < n; k++) begin
                w = 9'($urandom);
                exp_q.push_back(model_frame(w, cfg));
                write_word(w);
            end
            apply_stimulus($sformatf("rand%0d", it), n);
        end

        cfg = '0;
        cfg.frame_len = 4'b1000;
        exp_q.delete();
        for (int k = 0; k < DEPTH + 1; k++) begin
            if (k == DEPTH - 1) check_output("fill ready before last", tx_d_ready_o, 1);
            if (k == DEPTH) begin
                check_output("fill ready low", tx_d_ready_o, 0);
                check_output("fill fifo_full", tx_status_o.fifo_full, 1);
            end
            w = 9'($urandom);
            if (k < DEPTH) exp_q.push_back(model_frame(w, cfg));
            write_word(w);
        end
        apply_stimulus("fill", DEPTH);
        check_output("fill empty after", tx_status_o.fifo_empty, 1);

        cfg.flow_control = 1'b1;
        cts_n_i = 1'b1;
        write_word(9'h03C);
        write_word(9'h0C3);
        mark = line_q.size();
        tick_en = 1'b1;
        repeat (10 * BAUD) @(negedge clk);
        exp_q.delete();
        check_stream("cts hold", mark);
        check_output("cts hold busy", tx_status_o.busy, 0);
        mark = line_q.size();
        d0 = done_total;
        cts_n_i = 1'b0;
        c = 0;
        while (tx_o !== 1'b0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_output("cts latency in bound", (c <= 2 + BAUD + 1), 1);
        repeat (3 * BAUD) @(negedge clk);
        cts_n_i = 1'b1;
        c = 0;
        while (done_total - d0 < 1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (12 * BAUD) @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        check_output("cts done count", done_total - d0, 1);
        exp_q.delete();
        exp_q.push_back(model_frame(9'h03C, cfg));
        check_stream("cts drop", mark);
        check_output("cts second queued", tx_status_o.fifo_empty, 0);
        cfg.flush_tx = 1'b1;
        tx_d_valid_i = 1'b1;
        tx_d_i = 9'h155;
        @(negedge clk);
        cfg.flush_tx = 1'b0;
        tx_d_valid_i = 1'b0;
        @(negedge clk);
        check_output("flush empty", tx_status_o.fifo_empty, 1);
        cfg.flow_control = 1'b0;

        cfg = '0;
        cfg.frame_len = 4'b1000;
        write_word(9'h000);
        write_word(9'h00F);
        d0 = done_total;
        tick_en = 1'b1;
        c = 0;
        while (tx_o !== 1'b0 && c < 40) begin
            @(negedge clk);
            c++;
        end
        repeat (2 * BAUD + 1) @(negedge clk);
        check_output("pre-reset line low", tx_o, 0);
        check_output("pre-reset busy", tx_status_o.busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("reset async tx_o", tx_o, 1);
        check_output("reset async status", tx_status_o, 3'b001);
        check_output("reset async ready", tx_d_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mark = line_q.size();
        repeat (4 * BAUD) @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        check_output("reset no done", done_total - d0, 0);
        exp_q.delete();
        check_stream("reset idle", mark);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
